instruction_queue: RTL and testbench

Front-end buffer that turns fixed-width fetch words from the NOC-side fetch engine into one decoded-length instruction at a time for the core's sequencer. It accepts fetch words on a valid/ready handshake and stores them in a halfword ring buffer. It presents the head instruction (16, 32 or 48 bits) with `inst_pres`, pops it when the core raises `rq_nxt_inst`, and flushes and re-targets on a PC modification. It sits between the fetch engine and the core's instruction consumer: `curr_inst`, `inst_pres` and `rq_nxt_inst`.

---
 rtl/instruction_queue_pkg.sv | 25 ++
 rtl/instruction_queue_if.sv | 36 +++
 rtl/instruction_queue.sv | 105 ++++++++++
 tb/tb_instruction_queue.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_queue_pkg.sv
// Shared instruction-format definitions for the instruction queue and its consumers.
// Latency: n/a (types, constants and a pure combinational helper).
// Backpressure: n/a.
package instruction_queue_pkg;

    // Position of the length field inside the head halfword.
    localparam int INST_LEN_HI = 4;
    localparam int INST_LEN_LO = 3;

    // Widest instruction, in bits.
    localparam int INST_W = 48;

    typedef logic [INST_W-1:0] inst_t;

    // Returns the instruction length in halfwords (1..3). The reserved code 11 is
    // treated as a 48-bit instruction so that the decoder never stalls on it.
    function automatic logic [1:0] inst_len_hw(input logic [15:0] hw);
        case (hw[INST_LEN_HI:INST_LEN_LO])
            2'b00:   return 2'd1;
            2'b01:   return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/instruction_queue_if.sv
// Fetch-side and core-side signal bundle of the instruction queue.
// Latency: n/a (wiring only).
// Backpressure: fetch_ready qualifies fetch_valid; rq_nxt_inst only acts while inst_pres is 1.
interface instruction_queue_if
    import instruction_queue_pkg::*;
#(
    parameter int QUEUE_HW = 8,
    parameter int IN_WIDTH = 32
);
    localparam int OCC_W = $clog2(QUEUE_HW) + 1;

    logic                flush;
    logic [31:0]         new_pc;
    logic [IN_WIDTH-1:0] fetch_data;
    logic                fetch_valid;
    logic                fetch_ready;
    logic [31:0]         fetch_pc;
    inst_t               inst;
    logic                inst_pres;
    logic [31:0]         inst_pc;
    logic                rq_nxt_inst;
    logic [OCC_W-1:0]    occupancy;

    // Queue side.
    modport slave (
        input  flush, new_pc, fetch_data, fetch_valid, rq_nxt_inst,
        output fetch_ready, fetch_pc, inst, inst_pres, inst_pc, occupancy
    );

    // Fetch engine / core side.
    modport master (
        output flush, new_pc, fetch_data, fetch_valid, rq_nxt_inst,
        input  fetch_ready, fetch_pc, inst, inst_pres, inst_pc, occupancy
    );

endinterface

// File: rtl/instruction_queue.sv
// Halfword ring buffer that turns fetch words into one length-decoded instruction at a time.
// Latency: an accepted word is visible one cycle after its edge; head outputs are combinational from ring state.
// Backpressure: fetch_ready drops when free space (before any same-cycle pop) is below one fetch word, or on flush/reset.
module instruction_queue
    import instruction_queue_pkg::*;
#(
    parameter int QUEUE_HW = 8,
    parameter int IN_WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    instruction_queue_if.slave q
);
    localparam int PTR_W = $clog2(QUEUE_HW);
    localparam int OCC_W = PTR_W + 1;
    localparam int IN_HW = IN_WIDTH / 16;

    logic [15:0]      ring [QUEUE_HW];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [OCC_W-1:0] occ;
    logic [31:0]      fetch_pc_r;
    logic [31:0]      inst_pc_r;

    logic [15:0]      hw0;
    logic [15:0]      hw1;
    logic [15:0]      hw2;
    logic [1:0]       head_len;
    logic [OCC_W-1:0] head_len_w;
    logic             pres;
    logic             push;
    logic             pop;
    inst_t            inst_c;

    // Head window; pointer arithmetic wraps naturally because QUEUE_HW is a power of two.
    assign hw0        = ring[rd_ptr];
    assign hw1        = ring[rd_ptr + PTR_W'(1)];
    assign hw2        = ring[rd_ptr + PTR_W'(2)];
    assign head_len   = inst_len_hw(hw0);
    assign head_len_w = OCC_W'(head_len);

    // An empty queue never presents, whatever stale halfword sits under rd_ptr.
    assign pres = rst && (occ != '0) && (occ >= head_len_w);

    // Ready uses pre-pop occupancy so it never depends on rq_nxt_inst.
    assign q.fetch_ready = rst && !q.flush && ((QUEUE_HW - int'(occ)) >= IN_HW);

    assign push = q.fetch_valid && q.fetch_ready;
    assign pop  = q.rq_nxt_inst && pres;

    // Assemble the head instruction, zeroing halfwords beyond its length.
    always_comb begin
        inst_c = '0;
        if (pres) begin
            case (head_len)
                2'd1:    inst_c = {32'h0, hw0};
                2'd2:    inst_c = {16'h0, hw1, hw0};
                default: inst_c = {hw2, hw1, hw0};
            endcase
        end
    end

    // Pointer, occupancy and PC bookkeeping; reset beats flush, flush beats push/pop.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            occ        <= '0;
            fetch_pc_r <= '0;
            inst_pc_r  <= '0;
        end else if (q.flush) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            occ        <= '0;
            fetch_pc_r <= q.new_pc;
            inst_pc_r  <= q.new_pc;
        end else begin
            if (push) begin
                wr_ptr     <= wr_ptr + PTR_W'(IN_HW);
                fetch_pc_r <= fetch_pc_r + 32'(IN_WIDTH / 8);
            end
            if (pop) begin
                rd_ptr    <= rd_ptr + PTR_W'(head_len);
                inst_pc_r <= inst_pc_r + {29'd0, head_len, 1'b0};
            end
            occ <= occ + (push ? OCC_W'(IN_HW) : '0) - (pop ? head_len_w : '0);
        end
    end

    // Halfword storage; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            for (int i = 0; i < IN_HW; i++) begin
                ring[wr_ptr + PTR_W'(i)] <= q.fetch_data[16*i +: 16];
            end
        end
    end

    assign q.inst      = inst_c;
    assign q.inst_pres = pres;
    assign q.inst_pc   = inst_pc_r;
    assign q.fetch_pc  = fetch_pc_r;
    assign q.occupancy = occ;

endmodule

// File: tb/tb_instruction_queue.sv
// Directed bench for instruction_queue with a halfword-list reference model.
// Latency: model state follows the clock edge; outputs are compared at every falling edge.
// Backpressure: model accepts a word only when free space, before any pop, fits a whole word.
module tb_instruction_queue;
    localparam int QHW   = 8;
    localparam int INW   = 32;
    localparam int IN_HW = INW / 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    instruction_queue_if #(.QUEUE_HW(QHW), .IN_WIDTH(INW)) bus ();

    instruction_queue #(.QUEUE_HW(QHW), .IN_WIDTH(INW)) dut (
        .clk (clk),
        .rst (rst),
        .q   (bus)
    );

    // Reference model: program-ordered list of stored halfwords plus the two PCs.
    logic [15:0] mq [$];
    logic [31:0] m_fpc = 32'h0;
    logic [31:0] m_ipc = 32'h0;

    function automatic int m_len(input logic [15:0] h);
        if (h[4:3] == 2'b00) return 1;
        if (h[4:3] == 2'b01) return 2;
        return 3;
    endfunction

    function automatic logic m_pres();
        if (!rst || mq.size() == 0) return 1'b0;
        return mq.size() >= m_len(mq[0]);
    endfunction

    function automatic logic [47:0] m_inst();
        logic [47:0] e;
        e = '0;
        if (m_pres()) begin
            for (int i = 0; i < m_len(mq[0]); i++) e[16*i +: 16] = mq[i];
        end
        return e;
    endfunction

    function automatic logic m_ready();
        return rst && !bus.flush && ((QHW - mq.size()) >= IN_HW);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update on each rising edge, comparison against the DUT on each falling edge.
    initial begin
        forever begin
            @(posedge clk);
            if (!rst) begin
                mq.delete();
                m_fpc = 32'h0;
                m_ipc = 32'h0;
            end else if (bus.flush) begin
                mq.delete();
                m_fpc = bus.new_pc;
                m_ipc = bus.new_pc;
            end else begin
                logic do_pop;
                logic do_push;
                int   l;
                do_pop  = bus.rq_nxt_inst && m_pres();
                do_push = bus.fetch_valid && m_ready();
                if (do_pop) begin
                    l = m_len(mq[0]);
                    m_ipc = m_ipc + 32'(2 * l);
                    for (int i = 0; i < l; i++) void'(mq.pop_front());
                end
                if (do_push) begin
                    for (int i = 0; i < IN_HW; i++) mq.push_back(bus.fetch_data[16*i +: 16]);
                    m_fpc = m_fpc + 32'(INW / 8);
                end
            end
            @(negedge clk);
            chk("cyc_inst_pres",   64'(bus.inst_pres),   64'(m_pres()));
            chk("cyc_inst",        64'(bus.inst),        64'(m_inst()));
            chk("cyc_inst_pc",     64'(bus.inst_pc),     64'(m_ipc));
            chk("cyc_fetch_pc",    64'(bus.fetch_pc),    64'(m_fpc));
            chk("cyc_fetch_ready", 64'(bus.fetch_ready), 64'(m_ready()));
            chk("cyc_occupancy",   64'(bus.occupancy),   64'(mq.size()));
        end
    end

    task automatic idle();
        bus.fetch_valid = 1'b0;
        bus.fetch_data  = '0;
        bus.rq_nxt_inst = 1'b0;
        bus.flush       = 1'b0;
        bus.new_pc      = '0;
    endtask

    task automatic drive(input logic fv, input logic [31:0] fd, input logic rq,
                         input logic fl, input logic [31:0] npc);
        bus.fetch_valid = fv;
        bus.fetch_data  = fd;
        bus.rq_nxt_inst = rq;
        bus.flush       = fl;
        bus.new_pc      = npc;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle();
        #1;
    endtask

    // Hand-computed expectations for the directed scenarios.
    initial begin
        idle();
        rst = 1'b0;
        step();
        step();
        chk("rst_hold_ready", 64'(bus.fetch_ready), 64'd0);
        chk("rst_hold_pres",  64'(bus.inst_pres),   64'd0);
        chk("rst_hold_inst",  64'(bus.inst),        64'd0);
        rst = 1'b1;
        #1;
        chk("rst_pres",     64'(bus.inst_pres),   64'd0);
        chk("rst_occ",      64'(bus.occupancy),   64'd0);
        chk("rst_fetch_pc", 64'(bus.fetch_pc),    64'd0);
        chk("rst_ready",    64'(bus.fetch_ready), 64'd1);

        // 32-bit instruction.
        drive(1'b1, 32'hBBBB_0008, 1'b0, 1'b0, 32'h0);
        step();
        chk("i32_inst",     64'(bus.inst),      64'h0000_BBBB_0008);
        chk("i32_pres",     64'(bus.inst_pres), 64'd1);
        chk("i32_fetch_pc", 64'(bus.fetch_pc),  64'd4);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        step();
        chk("i32_pop_pc",   64'(bus.inst_pc),   64'd4);
        chk("i32_pop_pres", 64'(bus.inst_pres), 64'd0);

        // Straddling 48-bit instruction, starting from PC 0.
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
        step();
        drive(1'b1, 32'h2222_0010, 1'b0, 1'b0, 32'h0);
        step();
        chk("i48_partial_pres", 64'(bus.inst_pres), 64'd0);
        drive(1'b1, 32'h0000_3333, 1'b0, 1'b0, 32'h0);
        step();
        chk("i48_inst", 64'(bus.inst),      64'h3333_2222_0010);
        chk("i48_pres", 64'(bus.inst_pres), 64'd1);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        step();
        chk("i48_next_inst", 64'(bus.inst),      64'h0);
        chk("i48_next_pres", 64'(bus.inst_pres), 64'd1);
        chk("i48_next_pc",   64'(bus.inst_pc),   64'd6);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        step();
        chk("i48_drain_occ", 64'(bus.occupancy), 64'd0);

        // Full, conservative ready, and write-pointer wrap.
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
        step();
        drive(1'b1, 32'hA1A1_0008, 1'b0, 1'b0, 32'h0); step();
        drive(1'b1, 32'hA2A2_0009, 1'b0, 1'b0, 32'h0); step();
        drive(1'b1, 32'hA3A3_000A, 1'b0, 1'b0, 32'h0); step();
        drive(1'b1, 32'hA4A4_000B, 1'b0, 1'b0, 32'h0); step();
        chk("full_occ",      64'(bus.occupancy),   64'd8);
        chk("full_ready",    64'(bus.fetch_ready), 64'd0);
        chk("full_fetch_pc", 64'(bus.fetch_pc),    64'd16);
        drive(1'b1, 32'hA5A5_000C, 1'b1, 1'b0, 32'h0);
        chk("full_pop_ready_same", 64'(bus.fetch_ready), 64'd0);
        step();
        chk("full_pop_occ",   64'(bus.occupancy),   64'd6);
        chk("full_pop_ready", 64'(bus.fetch_ready), 64'd1);
        chk("full_pop_inst",  64'(bus.inst),        64'h0000_A2A2_0009);
        chk("full_pop_pc",    64'(bus.inst_pc),     64'd4);
        drive(1'b1, 32'hA5A5_000C, 1'b0, 1'b0, 32'h0);
        step();
        chk("wrap_occ", 64'(bus.occupancy), 64'd8);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0); step();
        chk("wrap_inst1", 64'(bus.inst), 64'h0000_A3A3_000A);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0); step();
        chk("wrap_inst2", 64'(bus.inst), 64'h0000_A4A4_000B);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0); step();
        chk("wrap_inst3", 64'(bus.inst), 64'h0000_A5A5_000C);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0); step();
        chk("wrap_end_pc",  64'(bus.inst_pc),   64'd20);
        chk("wrap_end_occ", 64'(bus.occupancy), 64'd0);

        // Flush beats a same-cycle push and pop.
        drive(1'b1, 32'h1234_0000, 1'b0, 1'b0, 32'h0);
        step();
        drive(1'b1, 32'h5678_0000, 1'b1, 1'b1, 32'h100);
        chk("flush_ready_same", 64'(bus.fetch_ready), 64'd0);
        step();
        chk("flush_occ",      64'(bus.occupancy), 64'd0);
        chk("flush_fetch_pc", 64'(bus.fetch_pc),  64'h100);
        chk("flush_inst_pc",  64'(bus.inst_pc),   64'h100);
        chk("flush_pres",     64'(bus.inst_pres), 64'd0);

        // Back-to-back 16-bit pops, with a push overlapping the first pop.
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
        step();
        drive(1'b1, 32'h0001_0004, 1'b0, 1'b0, 32'h0);
        step();
        chk("b2b_pc0", 64'(bus.inst_pc), 64'd0);
        chk("b2b_p0",  64'(bus.inst_pres), 64'd1);
        drive(1'b1, 32'h0002_0006, 1'b1, 1'b0, 32'h0);
        step();
        chk("b2b_pc1",  64'(bus.inst_pc),   64'd2);
        chk("b2b_p1",   64'(bus.inst_pres), 64'd1);
        chk("b2b_occ1", 64'(bus.occupancy), 64'd3);
        chk("b2b_i1",   64'(bus.inst),      64'h1);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0); step();
        chk("b2b_pc2", 64'(bus.inst_pc),   64'd4);
        chk("b2b_p2",  64'(bus.inst_pres), 64'd1);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0); step();
        chk("b2b_pc3", 64'(bus.inst_pc),   64'd6);
        chk("b2b_i3",  64'(bus.inst),      64'h2);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0); step();
        chk("b2b_end_pres", 64'(bus.inst_pres), 64'd0);
        chk("b2b_end_pc",   64'(bus.inst_pc),   64'd8);

        // Reset mid-operation discards contents.
        drive(1'b1, 32'h0001_0004, 1'b0, 1'b0, 32'h0);
        step();
        rst = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h40);
        step();
        rst = 1'b1;
        #1;
        chk("rst_mid_occ",  64'(bus.occupancy), 64'd0);
        chk("rst_mid_fpc",  64'(bus.fetch_pc),  64'd0);
        chk("rst_mid_pres", 64'(bus.inst_pres), 64'd0);
        step();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Time limit so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

endmodule
